// File: rtl/vgafetch_fifo.sv
// vgafetch_fifo: bus master that streams one frame of packed bitplane words
// from RAM into a small circular buffer. It presents the head word as four
// colour bytes, pops on the display's rd pulse and rewinds at each vsync.
module vgafetch_fifo #(
  parameter int ADDR_WIDTH  = 30,
  parameter int DEPTH_LOG2  = 4,
  parameter int FRAME_WORDS = 38400
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  addr_strobe,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic                  data_ready,
  input  logic [31:0]           data_in,
  input  logic                  rd,
  input  logic                  vsync_n,
  output logic [7:0]            red_byte,
  output logic [7:0]            green_byte,
  output logic [7:0]            blue_byte,
  output logic [7:0]            bright_byte,
  output logic                  underrun
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam int CNT_W = $clog2(FRAME_WORDS + 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t state, state_next;

  logic vs_meta, vs_sync, vs_hist;
  logic frame_start;

  logic [PTR_W-1:0] wr_ptr, rd_ptr, count;
  logic [PTR_W-1:0] wr_ptr_next, rd_ptr_next, count_next;
  logic [CNT_W-1:0] fetch_cnt;
  logic             frame_active;
  logic             discard;
  logic             wr_en;
  logic             pop;
  logic [31:0]      head_word;
  logic [31:0]      mem [DEPTH];

  // The synchronizer idles high so that leaving reset never looks like a vsync edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_meta <= 1'b1;
      vs_sync <= 1'b1;
      vs_hist <= 1'b1;
    end else begin
      vs_meta <= vsync_n;
      vs_sync <= vs_meta;
      vs_hist <= vs_sync;
    end
  end

  assign frame_start = vs_hist & ~vs_sync;

  assign count       = wr_ptr - rd_ptr;
  assign addr_strobe = (state == REQ);

  // A word acked after a rewind belongs to the old frame and is dropped
  assign wr_en = (state == REQ) && data_ready && !discard && !frame_start;
  assign pop   = rd && (count != '0) && !frame_start;

  // Next pointer values, shared by the pointer registers and the output register
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (frame_start) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (wr_en) wr_ptr_next = wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr_next = rd_ptr + PTR_W'(1);
    end
  end

  assign count_next = wr_ptr_next - rd_ptr_next;

  // Fetch FSM: a request is issued only from IDLE, which leaves a gap cycle after every ack
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (frame_active && (count < PTR_W'(DEPTH)) &&
            (fetch_cnt < CNT_W'(FRAME_WORDS)) && !frame_start)
          state_next = REQ;
      end
      REQ: begin
        if (data_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control registers; a rewind overrides any write or pop in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fetch_cnt    <= '0;
      addr         <= '0;
      underrun     <= 1'b0;
      frame_active <= 1'b0;
      discard      <= 1'b0;
    end else begin
      state  <= state_next;
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      if (frame_start) begin
        fetch_cnt    <= '0;
        addr         <= base_addr;
        underrun     <= 1'b0;
        frame_active <= 1'b1;
        discard      <= (state == REQ) && !data_ready;
      end else begin
        if (wr_en) begin
          fetch_cnt <= fetch_cnt + CNT_W'(1);
          addr      <= addr + ADDR_WIDTH'(1);
        end
        if ((state == REQ) && data_ready) discard <= 1'b0;
        if (rd && (count == '0)) underrun <= 1'b1;
      end
    end
  end

  // Buffer storage has no reset; only slots behind wr_ptr are ever read
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= data_in;
  end

  // Bypass so a word written into an empty buffer reaches the outputs with no extra cycle
  always_comb begin
    head_word = mem[rd_ptr_next[DEPTH_LOG2-1:0]];
    if (wr_en && (rd_ptr_next == wr_ptr)) head_word = data_in;
  end

  // Output register tracks the head word and holds while the buffer is empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red_byte    <= '0;
      green_byte  <= '0;
      blue_byte   <= '0;
      bright_byte <= '0;
    end else if (count_next != '0) begin
      red_byte    <= head_word[7:0];
      green_byte  <= head_word[15:8];
      blue_byte   <= head_word[23:16];
      bright_byte <= head_word[31:24];
    end
  end

endmodule

// File: tb/tb_vgafetch_fifo.sv
// tb_vgafetch_fifo: drives vgafetch_fifo with a bus responder, display pops
// and vsync pulses, and compares every cycle against a queue-based model.
module tb_vgafetch_fifo;

  localparam int AW    = 30;
  localparam int DL    = 4;
  localparam int FW    = 20;
  localparam int DEPTH = 16;

  logic          clk;
  logic          reset;
  logic [AW-1:0] base_addr;
  logic          addr_strobe;
  logic [AW-1:0] addr;
  logic          data_ready;
  logic [31:0]   data_in;
  logic          rd;
  logic          vsync_n;
  logic [7:0]    red_byte, green_byte, blue_byte, bright_byte;
  logic          underrun;

  int tests = 0;
  int failures = 0;

  // model state: buffer contents as a queue plus request/frame bookkeeping
  logic [31:0]   mq[$];
  bit            m_req, m_active, m_discard, m_under;
  int            m_fetched;
  logic [AW-1:0] m_base;
  bit            h1, h2, h3;
  logic [31:0]   m_out;

  // bus responder state
  int            ack_delay, hold_cnt, acks;
  logic [AW-1:0] last_ack_addr;
  logic [AW-1:0] ack_addrs[$];
  logic [31:0]   sent[$];
  bit            force_next;
  logic [31:0]   forced_word;

  typedef struct {
    logic [AW-1:0] base;
    int            delay;
    int            rd_every;
    int            cycles;
    int            exp_reqs;
    logic [AW-1:0] exp_last;
    bit            exp_under;
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] saved;
  int          waited, strobe_seen, vs_low;
  bit          rd_bit;

  vgafetch_fifo #(.ADDR_WIDTH(AW), .DEPTH_LOG2(DL), .FRAME_WORDS(FW)) dut (
    .clk(clk), .reset(reset), .base_addr(base_addr),
    .addr_strobe(addr_strobe), .addr(addr),
    .data_ready(data_ready), .data_in(data_in),
    .rd(rd), .vsync_n(vsync_n),
    .red_byte(red_byte), .green_byte(green_byte),
    .blue_byte(blue_byte), .bright_byte(bright_byte),
    .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_req = 0; m_active = 0; m_discard = 0; m_under = 0;
    m_fetched = 0; m_base = '0; m_out = '0;
    h1 = 1; h2 = 1; h3 = 1;
  endtask

  // advance the model by one clock using the inputs currently driven
  task automatic model_step();
    bit fs, ack, req_old;
    int sz;
    fs      = h3 && !h2;
    sz      = mq.size();
    req_old = m_req;
    ack     = req_old && data_ready;
    if (req_old) begin
      if (data_ready) m_req = 0;
    end else if (m_active && sz < DEPTH && m_fetched < FW && !fs) begin
      m_req = 1;
    end
    if (fs) begin
      mq.delete();
      m_fetched = 0;
      m_base    = base_addr;
      m_under   = 0;
      m_active  = 1;
      m_discard = req_old && !data_ready;
    end else begin
      if (ack) begin
        if (m_discard) m_discard = 0;
        else begin
          mq.push_back(data_in);
          m_fetched++;
        end
      end
      if (rd) begin
        if (sz > 0) void'(mq.pop_front());
        else m_under = 1;
      end
    end
    if (mq.size() > 0) m_out = mq[0];
    h3 = h2; h2 = h1; h1 = vsync_n;
  endtask

  task automatic check_model();
    logic [AW-1:0] ea;
    ea = m_base + AW'(m_fetched);
    check_output("strobe", addr_strobe, m_req);
    if (m_req) check_output("addr", addr, ea);
    check_output("bytes", {bright_byte, blue_byte, green_byte, red_byte}, m_out);
    check_output("underrun", underrun, m_under);
  endtask

  // one clock: respond to the bus, step the model, then compare after the edge
  task automatic apply_stimulus(input bit rd_in, input bit vs_in);
    bit strobe_now;
    rd         = rd_in;
    vsync_n    = vs_in;
    strobe_now = addr_strobe;
    data_ready = strobe_now && (hold_cnt >= ack_delay);
    data_in    = $urandom;
    if (data_ready) begin
      if (force_next) begin
        data_in    = forced_word;
        force_next = 0;
      end
      acks++;
      last_ack_addr = addr;
      ack_addrs.push_back(addr);
      sent.push_back(data_in);
    end
    model_step();
    @(posedge clk);
    #1;
    if (strobe_now && !data_ready) hold_cnt++;
    else hold_cnt = 0;
    check_model();
  endtask

  task automatic start_frame(input logic [AW-1:0] base);
    base_addr = base;
    repeat (3) apply_stimulus(1'b0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{30'h180,      2, 0, 120, 16, 30'h18F, 1'b0};
    vecs[1] = '{30'h200,      1, 4, 400, 20, 30'h213, 1'b1};
    vecs[2] = '{30'h3FFFFFFE, 0, 2, 300, 20, 30'h011, 1'b1};
    vecs[3] = '{30'h040,      3, 1, 300, 20, 30'h053, 1'b1};

    reset = 1; rd = 0; vsync_n = 1; data_ready = 0; data_in = '0; base_addr = '0;
    ack_delay = 2; hold_cnt = 0; acks = 0; force_next = 0; forced_word = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_model();
    reset = 0;

    // no fetching before the first frame start
    strobe_seen = 0;
    for (int i = 0; i < 100; i++) begin
      apply_stimulus(1'b0, 1'b1);
      if (addr_strobe) strobe_seen++;
    end
    check_output("idle_no_fetch", strobe_seen, 0);

    // fill to full from 0x100, check byte split, then one pop and one refill
    ack_delay = 2; force_next = 1; forced_word = 32'h44332211;
    acks = 0; sent.delete(); ack_addrs.delete();
    start_frame(30'h100);
    repeat (80) apply_stimulus(1'b0, 1'b1);
    check_output("fill_count", acks, 16);
    check_output("fill_first_addr", ack_addrs[0], 30'h100);
    check_output("fill_last_addr", last_ack_addr, 30'h10F);
    check_output("fill_stops", addr_strobe, 1'b0);
    check_output("first_word_bytes", {bright_byte, blue_byte, green_byte, red_byte}, 32'h44332211);
    apply_stimulus(1'b1, 1'b1);
    check_output("pop_next_word", {bright_byte, blue_byte, green_byte, red_byte}, sent[1]);
    acks = 0;
    repeat (20) apply_stimulus(1'b0, 1'b1);
    check_output("refill_one", acks, 1);
    check_output("refill_addr", last_ack_addr, 30'h110);

    // frame scenarios from the table
    for (int i = 0; i < 4; i++) begin
      ack_delay = vecs[i].delay;
      acks = 0;
      start_frame(vecs[i].base);
      for (int c = 0; c < vecs[i].cycles; c++) begin
        rd_bit = (vecs[i].rd_every == 0) ? 1'b0 : ((c % vecs[i].rd_every) == vecs[i].rd_every - 1);
        apply_stimulus(rd_bit, 1'b1);
      end
      check_output("vec_req_count", acks, vecs[i].exp_reqs);
      check_output("vec_last_addr", last_ack_addr, vecs[i].exp_last);
      check_output("vec_underrun", underrun, vecs[i].exp_under);
      check_output("vec_idle", addr_strobe, 1'b0);
    end

    // rd on an empty buffer right after a rewind
    ack_delay = 3;
    start_frame(30'h300);
    check_output("underrun_cleared", underrun, 1'b0);
    saved = m_out;
    apply_stimulus(1'b1, 1'b1);
    check_output("underrun_set", underrun, 1'b1);
    check_output("underrun_hold", {bright_byte, blue_byte, green_byte, red_byte}, saved);
    repeat (5) apply_stimulus(1'b0, 1'b1);
    start_frame(30'h340);
    check_output("underrun_next_frame", underrun, 1'b0);

    // rewind while a slow request is outstanding
    ack_delay = 5;
    start_frame(30'h500);
    waited = 0;
    while (!(addr_strobe && hold_cnt == 0) && waited < 40) begin
      apply_stimulus(1'b0, 1'b1);
      waited++;
    end
    check_output("discard_req_seen", addr_strobe, 1'b1);
    ack_addrs.delete();
    base_addr = 30'h600;
    repeat (3) apply_stimulus(1'b0, 1'b0);
    repeat (30) apply_stimulus(1'b0, 1'b1);
    check_output("discard_ack_addr", ack_addrs[0], 30'h600);
    check_output("refetch_base", ack_addrs[1], 30'h600);
    check_output("refetch_next", ack_addrs[2], 30'h601);

    // reset in the middle of a request
    waited = 0;
    while (!addr_strobe && waited < 40) begin
      apply_stimulus(1'b0, 1'b1);
      waited++;
    end
    check_output("reset_req_seen", addr_strobe, 1'b1);
    reset = 1;
    #1;
    check_output("async_strobe_drop", addr_strobe, 1'b0);
    model_reset();
    data_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check_model();
    data_ready = 0;
    hold_cnt = 0;
    reset = 0;
    repeat (10) apply_stimulus(1'b0, 1'b1);

    // randomized traffic with occasional rewinds
    base_addr = AW'($urandom);
    vs_low = 3;
    for (int i = 0; i < 1500; i++) begin
      if (vs_low == 0 && $urandom_range(0, 199) == 0) begin
        base_addr = ($urandom_range(0, 3) == 0) ? 30'h3FFFFFF8 : AW'($urandom);
        vs_low = 3;
      end
      if (hold_cnt == 0) ack_delay = $urandom_range(0, 4);
      apply_stimulus($urandom_range(0, 3) == 0, vs_low == 0);
      if (vs_low > 0) vs_low--;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
